ps2_key_encoder: RTL

//  Transmit end of the 11-bit ps2_key event word that the core top level consumes
//  ({toggle, pressed, extended, code[7:0]}).

---
 rtl/ps2_key_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deserialises frames, resolves
// E0/F0 prefixes and emits one toggle-flagged {toggle, pressed, extended, code} word per key event.
module ps2_key_encoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ps2_clk_in,
    input  logic        i_ps2_dat_in,
    output logic [10:0] o_ps2_key,
    output logic        o_key_strobe,
    output logic        o_frame_err
);

    localparam int unsigned FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_filt;
    logic [FCW-1:0] r_fcnt;
    logic [3:0]     r_bitcnt;
    logic [10:0]    r_shift;
    logic           r_done, r_byte_valid, r_frame_err;
    logic [TCW-1:0] r_idle;
    logic [10:0]    r_ps2_key;
    logic           r_key_strobe;
    state_e         r_state, w_state_next;

    logic           w_fall, w_start_err, w_timeout, w_frame_ok;
    logic [7:0]     w_byte;
    logic           w_is_ack, w_emit, w_ext, w_brk;

    // Filtered clock falls in the same cycle the last required differing sample arrives.
    assign w_fall      = r_filt && !r_clk_s2 && (r_fcnt == FCW'(FILTER_LEN - 1));
    assign w_start_err = w_fall && (r_bitcnt == 4'd0) && r_dat_s2;
    assign w_timeout   = !w_fall && (r_bitcnt != 4'd0) && (r_idle == TCW'(TIMEOUT - 1));
    assign w_frame_ok  = !r_shift[0] && (^r_shift[9:1]) && r_shift[10];
    assign w_byte      = r_shift[8:1];

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_bitcnt     <= 4'd0;
            r_shift      <= '0;
            r_done       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_idle       <= '0;
        end else begin
            r_done       <= 1'b0;
            r_byte_valid <= r_done && w_frame_ok;
            r_frame_err  <= w_start_err || w_timeout || (r_done && !w_frame_ok);
            if (w_fall) begin
                r_idle <= '0;
                if (!w_start_err) begin
                    r_shift <= {r_dat_s2, r_shift[10:1]};
                    if (r_bitcnt == 4'd10) begin
                        r_bitcnt <= 4'd0;
                        r_done   <= 1'b1;
                    end else begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
            end else if (w_timeout) begin
                r_bitcnt <= 4'd0;
                r_idle   <= '0;
            end else if (r_idle != TCW'(TIMEOUT - 1)) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_is_ack = (w_byte == 8'hFA) || (w_byte == 8'hAA) || (w_byte == 8'hEE) ||
                   (w_byte == 8'hFE) || (w_byte == 8'hFC);
        w_state_next = r_state;
        if (r_frame_err) begin
            w_state_next = StIdle;
        end else if (r_byte_valid) begin
            if (w_byte == 8'hE0) begin
                w_state_next = StExt;
            end else if (w_byte == 8'hF0) begin
                unique case (r_state)
                    StIdle:  w_state_next = StBrk;
                    StExt:   w_state_next = StExtBrk;
                    default: w_state_next = r_state;
                endcase
            end else begin
                w_state_next = StIdle;
            end
        end
    end

    always_comb begin
        w_ext  = (r_state == StExt) || (r_state == StExtBrk);
        w_brk  = (r_state == StBrk) || (r_state == StExtBrk);
        w_emit = r_byte_valid && (w_byte != 8'hE0) && (w_byte != 8'hF0) &&
                 !((r_state == StIdle) && w_is_ack);
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_ps2_key    <= '0;
            r_key_strobe <= 1'b0;
        end else begin
            r_key_strobe <= w_emit;
            if (w_emit) begin
                r_ps2_key <= {~r_ps2_key[10], ~w_brk, w_ext, w_byte};
            end
        end
    end

    assign o_ps2_key    = r_ps2_key;
    assign o_key_strobe = r_key_strobe;
    assign o_frame_err  = r_frame_err;

endmodule
